univ_shift_reg_param: RTL and testbench
=======================================

UNIV_SHIFT_REG_PARAM -- requirements
Module: univ_shift_reg_param

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 Parameter CNT_W, default 4, width of the step-count input.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  command strobe, sampled only in IDLE.
REQ-006 mode  input  3  operation code, sampled with start.
REQ-007 amount  input  CNT_W  number of single-bit steps for shift/rotate modes, sampled with start.
REQ-008 sin_lsb  input  1  serial bit entering bit 0 on shift-up steps.
REQ-009 sin_msb  input  1  serial bit entering bit WIDTH-1 on shift-down steps.
REQ-010 din  input  WIDTH  parallel load data.
REQ-011 q  output  WIDTH  register contents.
REQ-012 sout_msb  output  1  equals q[WIDTH-1], combinational from q.
REQ-013 sout_lsb  output  1  equals q[0], combinational from q.
REQ-014 busy  output  1  high while a multi-step operation has steps remaining.
REQ-015 done  output  1  one-cycle pulse after an accepted command completes.

Function
REQ-016 Mode encoding SHALL be: 000 hold, 001 shift up (q<={q[W-2:0],sin_lsb}), 010 shift down (q<={sin_msb,q[W-1:1]}), 011 load din, 100 rotate up, 101 rotate down, 110 arithmetic shift down (MSB replicated), 111 synchronous clear.
REQ-017 FSM SHALL have two states: IDLE, RUN.
REQ-018 In IDLE with start=0, q SHALL hold and done SHALL be 0.
REQ-019 Modes 000, 011 and 111 accepted in IDLE SHALL complete at the accepting edge, stay in IDLE and assert done for the following cycle; amount is ignored.
REQ-020 Shift/rotate modes accepted with amount=N≥1 SHALL perform step 1 at the accepting edge and one further step per rising edge, N steps total.
REQ-021 If N≥2, FSM SHALL enter RUN with busy=1 and a remaining count of N-1; busy SHALL fall at the edge performing step N.
REQ-022 done SHALL be asserted for exactly the one cycle following the edge performing the final step.
REQ-023 Shift/rotate mode with amount=0 SHALL leave q unchanged and assert done for the next cycle.
REQ-024 sin_lsb/sin_msb SHALL be sampled live at each step edge, not latched at start.
REQ-025 mode and amount SHALL be latched at acceptance; changes during RUN SHALL have no effect.
REQ-026 start asserted while busy=1 SHALL be ignored (not queued).
REQ-027 start asserted in the cycle done is high SHALL be accepted normally (back-to-back commands).
REQ-028 amount greater than WIDTH SHALL be executed literally (rotates wrap, shifts fill fully with serial/sign bits).

Reset
REQ-029 clr=1 SHALL immediately force q=0, state IDLE, busy=0, done=0, remaining count 0, independent of clk.
REQ-030 clr during RUN SHALL abort the operation with no done pulse; first command is accepted at the first edge after clr deasserts.

Structure
REQ-031 Mode encodings SHALL be named constants in shared package usr_pkg.
REQ-032 Single-step next-value logic SHALL be a combinational sub-module usr_step (inputs q, mode, sin_lsb, sin_msb; output next q).

Verification (WIDTH=8, CNT_W=4)
REQ-033 clr pulse mid-RUN (shift up, N=5, after step 2) -> q=00 immediately, busy=0, no done; next load accepted.
REQ-034 Load din=A5, mode 011 -> q=A5 after one edge, done one cycle, busy never high.
REQ-035 q=81, rotate up N=3 -> q=03,06,0C on successive edges; busy high 2 cycles; done after third edge.
REQ-036 q=80, arithmetic shift down N=2 -> q=C0 then E0; sout_msb=1 throughout.
REQ-037 q=00, shift down N=4 with sin_msb driven 1,0,1,1 per edge -> q=D0; start pulses during busy ignored, q unaffected.
REQ-038 Shift up N=0 -> q unchanged, done one cycle; immediate restart on done cycle with mode 111 -> q=00.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared constants for the universal shift register: operation codes,
// FSM states and a classifier for the multi-step operations.
package usr_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHL   = 3'b001,
        MODE_SHR   = 3'b010,
        MODE_LOAD  = 3'b011,
        MODE_ROL   = 3'b100,
        MODE_ROR   = 3'b101,
        MODE_ASR   = 3'b110,
        MODE_CLEAR = 3'b111
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Shift and rotate codes consume the step count; the rest finish in one edge.
    function automatic logic is_step_mode(input logic [2:0] m);
        logic r;
        case (m)
            MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR: r = 1'b1;
            default:                                          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/usr_step.sv
// Single-bit step of the shift/rotate datapath; non-step codes pass q through.
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic             sin_lsb,
    input  logic             sin_msb,
    output logic [WIDTH-1:0] q_next
);

    // One step of the selected shift or rotate.
    always_comb begin
        q_next = q;
        case (mode)
            MODE_SHL: q_next = {q[WIDTH-2:0], sin_lsb};
            MODE_SHR: q_next = {sin_msb, q[WIDTH-1:1]};
            MODE_ROL: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR: q_next = {q[0], q[WIDTH-1:1]};
            MODE_ASR: q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            default:  q_next = q;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg_param.sv
// Universal shift register with multi-step shift/rotate commands sequenced
// by a two-state FSM; single-edge commands complete directly from IDLE.
module univ_shift_reg_param
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] amount,
    input  logic             sin_lsb,
    input  logic             sin_msb,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [2:0]       mode_r, mode_s;
    logic [WIDTH-1:0] q_r, q_s, step_q_s;
    logic [2:0]       step_mode_s;
    logic             done_r, done_s;
    logic             busy_r, busy_s;

    // In RUN the latched code drives the stepper so live mode changes are ignored.
    assign step_mode_s = (state_r == ST_RUN) ? mode_r : mode;

    usr_step #(.WIDTH(WIDTH)) u_step (
        .q       (q_r),
        .mode    (step_mode_s),
        .sin_lsb (sin_lsb),
        .sin_msb (sin_msb),
        .q_next  (step_q_s)
    );

    // State register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state: RUN only when a step command still has steps after the first.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && is_step_mode(mode) && (amount > CNT_ONE)) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == CNT_ONE) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Datapath and flag next values.
    always_comb begin
        q_s    = q_r;
        cnt_s  = cnt_r;
        mode_s = mode_r;
        done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (is_step_mode(mode)) begin
                        if (amount == '0) begin
                            done_s = 1'b1;
                        end else if (amount == CNT_ONE) begin
                            q_s    = step_q_s;
                            done_s = 1'b1;
                        end else begin
                            q_s    = step_q_s;
                            cnt_s  = amount - CNT_ONE;
                            mode_s = mode;
                        end
                    end else begin
                        case (mode)
                            MODE_LOAD:  q_s = din;
                            MODE_CLEAR: q_s = '0;
                            default:    q_s = q_r;
                        endcase
                        done_s = 1'b1;
                    end
                end else begin
                    q_s = q_r;
                end
            end
            ST_RUN: begin
                q_s   = step_q_s;
                cnt_s = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    done_s = 1'b1;
                end else begin
                    done_s = 1'b0;
                end
            end
            default: q_s = q_r;
        endcase
        busy_s = (state_s == ST_RUN);
    end

    // Datapath and flag registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q_r    <= '0;
            cnt_r  <= '0;
            mode_r <= MODE_HOLD;
            done_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            q_r    <= q_s;
            cnt_r  <= cnt_s;
            mode_r <= mode_s;
            done_r <= done_s;
            busy_r <= busy_s;
        end
    end

    assign q        = q_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign sout_msb = q_r[WIDTH-1];
    assign sout_lsb = q_r[0];

endmodule

// File: tb/tb_univ_shift_reg_param.sv
// Directed bench for univ_shift_reg_param at WIDTH=8, CNT_W=4 with
// hand-computed expected register and flag values.
module tb_univ_shift_reg_param;

    logic       clk;
    logic       clr;
    logic       start;
    logic [2:0] mode;
    logic [3:0] amount;
    logic       sin_lsb;
    logic       sin_msb;
    logic [7:0] din;
    logic [7:0] q;
    logic       sout_msb;
    logic       sout_lsb;
    logic       busy;
    logic       done;

    int vectors;
    int miscompares;

    univ_shift_reg_param #(.WIDTH(8), .CNT_W(4)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .mode     (mode),
        .amount   (amount),
        .sin_lsb  (sin_lsb),
        .sin_msb  (sin_msb),
        .din      (din),
        .q        (q),
        .sout_msb (sout_msb),
        .sout_lsb (sout_lsb),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic st(input string tag, input logic [7:0] q_exp, input logic b_exp, input logic d_exp);
        chk8({tag, "_q"}, q, q_exp);
        chk1({tag, "_busy"}, busy, b_exp);
        chk1({tag, "_done"}, done, d_exp);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clr     = 1'b1;
        start   = 1'b0;
        mode    = 3'b000;
        amount  = 4'd0;
        sin_lsb = 1'b0;
        sin_msb = 1'b0;
        din     = 8'h00;
        #1;
        st("reset", 8'h00, 1'b0, 1'b0);
        chk1("reset_sout_lsb", sout_lsb, 1'b0);
        @(negedge clk);
        clr = 1'b0;

        // Load A5, then idle with start low holds the value.
        start = 1'b1; mode = 3'b011; din = 8'hA5;
        tick(); st("load_a5", 8'hA5, 1'b0, 1'b1);
        start = 1'b0;
        tick(); st("idle_hold", 8'hA5, 1'b0, 1'b0);

        // Explicit hold command, then back-to-back load 81.
        start = 1'b1; mode = 3'b000;
        tick(); st("hold_cmd", 8'hA5, 1'b0, 1'b1);
        mode = 3'b011; din = 8'h81;
        tick(); st("load_81", 8'h81, 1'b0, 1'b1);

        // Rotate up 3 accepted on the done cycle; mode/amount changes in RUN ignored.
        mode = 3'b100; amount = 4'd3;
        tick(); st("rol_s1", 8'h03, 1'b1, 1'b0);
        start = 1'b0; mode = 3'b111; amount = 4'd0;
        tick(); st("rol_s2", 8'h06, 1'b1, 1'b0);
        tick(); st("rol_s3", 8'h0C, 1'b0, 1'b1);
        tick(); st("rol_after", 8'h0C, 1'b0, 1'b0);

        // Arithmetic shift down 2 from 80.
        start = 1'b1; mode = 3'b011; din = 8'h80;
        tick(); st("load_80", 8'h80, 1'b0, 1'b1);
        mode = 3'b110; amount = 4'd2;
        tick(); st("asr_s1", 8'hC0, 1'b1, 1'b0);
        chk1("asr_s1_msb", sout_msb, 1'b1);
        start = 1'b0;
        tick(); st("asr_s2", 8'hE0, 1'b0, 1'b1);
        chk1("asr_s2_msb", sout_msb, 1'b1);

        // Shift down 4 with live sin_msb 1,0,1,1; loads attempted while busy ignored.
        start = 1'b1; mode = 3'b011; din = 8'h00;
        tick(); st("load_00", 8'h00, 1'b0, 1'b1);
        mode = 3'b010; amount = 4'd4; sin_msb = 1'b1;
        tick(); st("shr_s1", 8'h80, 1'b1, 1'b0);
        mode = 3'b011; din = 8'hFF; sin_msb = 1'b0;
        tick(); st("shr_s2", 8'h40, 1'b1, 1'b0);
        start = 1'b0; sin_msb = 1'b1;
        tick(); st("shr_s3", 8'hA0, 1'b1, 1'b0);
        start = 1'b1;
        tick(); st("shr_s4", 8'hD0, 1'b0, 1'b1);
        start = 1'b0;
        tick(); st("shr_after", 8'hD0, 1'b0, 1'b0);

        // Zero-step shift up, then clear issued on its done cycle.
        start = 1'b1; mode = 3'b001; amount = 4'd0; sin_lsb = 1'b1;
        tick(); st("shl_n0", 8'hD0, 1'b0, 1'b1);
        mode = 3'b111;
        tick(); st("clear_cmd", 8'h00, 1'b0, 1'b1);
        start = 1'b0;
        tick(); st("clear_after", 8'h00, 1'b0, 1'b0);

        // Rotate up 9 on an 8-bit register equals one rotate.
        start = 1'b1; mode = 3'b011; din = 8'h3C;
        tick(); st("load_3c", 8'h3C, 1'b0, 1'b1);
        mode = 3'b100; amount = 4'd9;
        tick(); st("rol9_s1", 8'h78, 1'b1, 1'b0);
        start = 1'b0;
        for (int i = 2; i <= 8; i++) begin
            tick(); chk1("rol9_busy", busy, 1'b1);
        end
        tick(); st("rol9_end", 8'h78, 1'b0, 1'b1);

        // Shift up 15 fills completely with sin_lsb.
        start = 1'b1; mode = 3'b001; amount = 4'd15; sin_lsb = 1'b1;
        tick(); st("shl15_s1", 8'hF1, 1'b1, 1'b0);
        start = 1'b0;
        for (int i = 2; i <= 14; i++) begin
            tick(); chk1("shl15_done_low", done, 1'b0);
        end
        tick(); st("shl15_end", 8'hFF, 1'b0, 1'b1);
        chk1("shl15_lsb", sout_lsb, 1'b1);

        // Clear pulse mid-RUN aborts with no done; next load accepted.
        start = 1'b1; mode = 3'b011; din = 8'h01;
        tick(); st("load_01", 8'h01, 1'b0, 1'b1);
        mode = 3'b001; amount = 4'd5; sin_lsb = 1'b1;
        tick(); st("abort_s1", 8'h03, 1'b1, 1'b0);
        start = 1'b0;
        tick(); st("abort_s2", 8'h07, 1'b1, 1'b0);
        #2 clr = 1'b1;
        #1;
        st("abort_async", 8'h00, 1'b0, 1'b0);
        tick(); st("abort_held", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        clr = 1'b0;
        start = 1'b1; mode = 3'b011; din = 8'h3C;
        tick(); st("post_clr_load", 8'h3C, 1'b0, 1'b1);
        start = 1'b0;
        tick(); st("post_clr_idle", 8'h3C, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
